// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared types and constants for the PWM duty ramp and the
//            PWMGenerator it feeds.
// Contents : ramp_state_t  - ramp controller states (IDLE/UP/DOWN)
//            PWM_SIZE      - default duty code width, shared with PWMGenerator
//            TICK_CNT_W    - width of the Synch pulse counter
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ramp_state_t;

    localparam int unsigned PWM_SIZE   = 3;
    localparam int unsigned TICK_CNT_W = 8;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_duty_ramp_synch_divider.sv
`default_nettype none
// ============================================================================
// Module   : synch_divider
// Purpose  : Counts PWM period-start pulses and emits a one-cycle step enable
//            on every TicksPerStep-th pulse.
// Ports    : Clock   - system clock, rising edge
//            Reset_n - asynchronous active-low reset
//            Clear   - synchronous counter clear (wins over Synch)
//            Synch   - one-cycle period-start pulse from PWMGenerator
//            StepEn  - high in the cycle whose rising edge should take a step
// Revision : 1.0 - initial release
// ============================================================================
module synch_divider
    import pwm_pkg::*;
#(
    parameter int TicksPerStep = 1
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Clear,
    input  logic Synch,
    output logic StepEn
);

    localparam logic [TICK_CNT_W-1:0] c_last = TICK_CNT_W'(TicksPerStep - 1);

    logic [TICK_CNT_W-1:0] cnt_q;
    logic [TICK_CNT_W-1:0] cnt_d;
    logic                  step_en;

    always_comb begin
        cnt_d   = cnt_q;
        step_en = 1'b0;
        if (Clear) begin
            cnt_d = '0;
        end else if (Synch) begin
            if (cnt_q == c_last) begin
                cnt_d   = '0;
                step_en = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational: the step lands on the same edge that sees the last Synch.
    assign StepEn = step_en;

endmodule : synch_divider
`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_ramp
// Purpose  : Moves the PWMGenerator duty code toward a requested target in
//            saturating steps of Step, one step every TicksPerStep generator
//            periods, so duty changes only on period boundaries.
// Ports    : Clock, Reset_n        - clock / asynchronous active-low reset
//            Target, TargetValid   - requested duty code and its valid
//            TargetReady           - high only while idle
//            Abort                 - stop a ramp, hold the current Data
//            Synch                 - period-start pulse from PWMGenerator
//            Data                  - duty code to PWMGenerator
//            Busy                  - ramp in progress
//            Done                  - one-cycle pulse, Data reached target
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int Size         = PWM_SIZE,
    parameter int Step         = 1,
    parameter int TicksPerStep = 1
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [Size-1:0] Target,
    input  logic            TargetValid,
    output logic            TargetReady,
    input  logic            Abort,
    input  logic            Synch,
    output logic [Size-1:0] Data,
    output logic            Busy,
    output logic            Done
);

    localparam logic [Size:0] c_step = (Size + 1)'(Step);

    ramp_state_t     state_q, state_d;
    logic [Size-1:0] data_q,  data_d;
    logic [Size-1:0] tgt_q,   tgt_d;
    logic            done_q,  done_d;

    logic            clear;
    logic            step_en;
    logic [Size:0]   sum;
    logic [Size:0]   diff;

    // Counter only runs while ramping; holding it clear in IDLE also makes a
    // Synch coincident with the accept edge uncounted.
    assign clear = (state_q == ST_IDLE) || Abort;

    synch_divider #(
        .TicksPerStep (TicksPerStep)
    ) u_synch_divider (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Clear   (clear),
        .Synch   (Synch),
        .StepEn  (step_en)
    );

    // One extra bit: sum never wraps, and diff's MSB is the borrow.
    assign sum  = {1'b0, data_q} + c_step;
    assign diff = {1'b0, data_q} - c_step;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (TargetValid) begin
                    tgt_d = Target;
                    if (Target > data_q) begin
                        state_d = ST_UP;
                    end else if (Target < data_q) begin
                        state_d = ST_DOWN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_UP: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else if (step_en) begin
                    if (sum >= {1'b0, tgt_q}) begin
                        data_d  = tgt_q;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        data_d = sum[Size-1:0];
                    end
                end
            end

            ST_DOWN: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else if (step_en) begin
                    if (diff[Size] || (diff[Size-1:0] <= tgt_q)) begin
                        data_d  = tgt_q;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        data_d = diff[Size-1:0];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign TargetReady = (state_q == ST_IDLE);
    assign Busy        = (state_q != ST_IDLE);
    assign Done        = done_q;
    assign Data        = data_q;

endmodule : pwm_duty_ramp
`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_ramp
// Purpose  : Self-checking bench for pwm_duty_ramp. Three instances:
//            u0 Step=1 TicksPerStep=1, u1 Step=4 TicksPerStep=1,
//            u2 Step=1 TicksPerStep=3. A behavioural model per instance is
//            compared every cycle; directed sequences pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ramp;

    localparam int c_per   = 50;               // clocks between Synch pulses
    localparam int c_bound = 4 * c_per * 3;    // wait budget per data step

    localparam int c_step [3] = '{1, 4, 1};
    localparam int c_tps  [3] = '{1, 1, 3};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       synch = 1'b0;
    logic [2:0] tgt   [3];
    logic       tv    [3];
    logic       ab    [3];
    logic [2:0] data_w  [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       ready_w [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.Size(3), .Step(1), .TicksPerStep(1)) u0 (
        .Clock(clk), .Reset_n(rst_n), .Target(tgt[0]), .TargetValid(tv[0]),
        .TargetReady(ready_w[0]), .Abort(ab[0]), .Synch(synch),
        .Data(data_w[0]), .Busy(busy_w[0]), .Done(done_w[0]));

    pwm_duty_ramp #(.Size(3), .Step(4), .TicksPerStep(1)) u1 (
        .Clock(clk), .Reset_n(rst_n), .Target(tgt[1]), .TargetValid(tv[1]),
        .TargetReady(ready_w[1]), .Abort(ab[1]), .Synch(synch),
        .Data(data_w[1]), .Busy(busy_w[1]), .Done(done_w[1]));

    pwm_duty_ramp #(.Size(3), .Step(1), .TicksPerStep(3)) u2 (
        .Clock(clk), .Reset_n(rst_n), .Target(tgt[2]), .TargetValid(tv[2]),
        .TargetReady(ready_w[2]), .Abort(ab[2]), .Synch(synch),
        .Data(data_w[2]), .Busy(busy_w[2]), .Done(done_w[2]));

    // Period-start pulse, one clock wide, changed just after the edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1 synch = ((cyc % c_per) == 0);
    end

    // ------------------------------------------------------------------
    // Behavioural model: mode 0 idle, +1 ramping up, -1 ramping down.
    // ------------------------------------------------------------------
    int m_data [3];
    int m_tgt  [3];
    int m_mode [3];
    int m_cnt  [3];
    int m_done [3];

    task automatic model_step(input int i);
        int nxt;
        m_done[i] = 0;
        if (m_mode[i] == 0) begin
            if (tv[i]) begin
                m_tgt[i] = int'(tgt[i]);
                m_cnt[i] = 0;
                if (m_tgt[i] > m_data[i])      m_mode[i] = 1;
                else if (m_tgt[i] < m_data[i]) m_mode[i] = -1;
                else                           m_done[i] = 1;
            end
        end else if (ab[i]) begin
            m_mode[i] = 0;
            m_cnt[i]  = 0;
        end else if (synch) begin
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] == c_tps[i]) begin
                m_cnt[i] = 0;
                if (m_mode[i] == 1) begin
                    nxt = m_data[i] + c_step[i];
                    if (nxt > m_tgt[i]) nxt = m_tgt[i];
                end else begin
                    nxt = m_data[i] - c_step[i];
                    if (nxt < m_tgt[i]) nxt = m_tgt[i];
                end
                m_data[i] = nxt;
                if (nxt == m_tgt[i]) begin
                    m_mode[i] = 0;
                    m_done[i] = 1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_data[i] = 0; m_tgt[i] = 0; m_mode[i] = 0;
                m_cnt[i]  = 0; m_done[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests = n_tests + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.Data", i),  int'(data_w[i]),  m_data[i]);
            chk($sformatf("u%0d.Busy", i),  int'(busy_w[i]),  int'(m_mode[i] != 0));
            chk($sformatf("u%0d.Done", i),  int'(done_w[i]),  m_done[i]);
            chk($sformatf("u%0d.Ready", i), int'(ready_w[i]), int'(m_mode[i] == 0));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input int i, input int t);
        chk($sformatf("u%0d.ready_before_accept", i), int'(ready_w[i]), 1);
        tv[i]  = 1'b1;
        tgt[i] = 3'(t);
        tick();
        tv[i]  = 1'b0;
    endtask

    // Wait for each Data change and pin it to the literal list; when fin is
    // set, the last change must coincide with a one-cycle Done and Busy=0.
    task automatic expect_steps(input int i, input int exp [6], input int n,
                                input bit fin, input string nm);
        int prev;
        int t;
        for (int k = 0; k < n; k++) begin
            prev = int'(data_w[i]);
            t = 0;
            while (int'(data_w[i]) == prev && t < c_bound) begin
                tick();
                t++;
            end
            if (t >= c_bound) begin
                n_tests = n_tests + 1;
                n_fail  = n_fail + 1;
                $display("FAIL %s_timeout: step %0d got no change, expected %0d", nm, k, exp[k]);
                return;
            end
            chk($sformatf("%s_step%0d", nm, k), int'(data_w[i]), exp[k]);
        end
        if (fin) begin
            chk({nm, "_done"},      int'(done_w[i]), 1);
            chk({nm, "_busy_end"},  int'(busy_w[i]), 0);
            tick();
            chk({nm, "_done_pulse"}, int'(done_w[i]), 0);
        end
    endtask

    task automatic wait_synch(input string nm);
        int t = 0;
        while (!synch && t < c_bound) begin
            tick();
            t++;
        end
        if (t >= c_bound) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL %s_timeout: no Synch seen, expected 1", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            tgt[i] = '0; tv[i] = 1'b0; ab[i] = 1'b0;
        end

        // Reset values
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk("reset_data",  int'(data_w[i]),  0);
            chk("reset_busy",  int'(busy_w[i]),  0);
            chk("reset_done",  int'(done_w[i]),  0);
            chk("reset_ready", int'(ready_w[i]), 1);
        end
        rst_n = 1'b1;
        tick();

        // 1. Asynchronous reset mid-ramp, checked before any clock edge
        accept(0, 6);
        expect_steps(0, '{1, 0, 0, 0, 0, 0}, 1, 1'b0, "pre_reset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_data",  int'(data_w[0]),  0);
        chk("async_rst_busy",  int'(busy_w[0]),  0);
        chk("async_rst_done",  int'(done_w[0]),  0);
        chk("async_rst_ready", int'(ready_w[0]), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // 2. Ramp up 0 -> 6
        accept(0, 6);
        chk("ramp_up_busy", int'(busy_w[0]), 1);
        expect_steps(0, '{1, 2, 3, 4, 5, 6}, 6, 1'b1, "ramp_up");

        // 4. Equal target: 6 -> 5, then accept 5 again
        accept(0, 5);
        expect_steps(0, '{5, 0, 0, 0, 0, 0}, 1, 1'b1, "to5");
        accept(0, 5);
        chk("equal_done", int'(done_w[0]), 1);
        chk("equal_busy", int'(busy_w[0]), 0);
        chk("equal_data", int'(data_w[0]), 5);
        tick();
        chk("equal_done_pulse", int'(done_w[0]), 0);

        // 3. Saturation with Step=4
        accept(1, 7);
        expect_steps(1, '{4, 7, 0, 0, 0, 0}, 2, 1'b1, "sat_up");
        accept(1, 1);
        expect_steps(1, '{3, 1, 0, 0, 0, 0}, 2, 1'b1, "sat_down");

        // Abort in IDLE does not block a same-cycle accept
        ab[1] = 1'b1; tv[1] = 1'b1; tgt[1] = 3'd3;
        tick();
        ab[1] = 1'b0; tv[1] = 1'b0;
        chk("abort_idle_accept", int'(busy_w[1]), 1);
        expect_steps(1, '{3, 0, 0, 0, 0, 0}, 1, 1'b1, "abort_idle");

        // 5. Pacing with TicksPerStep=3; accept coincides with a Synch
        wait_synch("pace");
        tv[2] = 1'b1; tgt[2] = 3'd2;
        tick();
        tv[2] = 1'b0;
        n = 0;
        for (int t = 0; t < c_bound; t++) begin
            if (int'(data_w[2]) == 1) break;
            if (synch) n++;
            tick();
        end
        chk("pace_synchs_to_1", n, 3);
        chk("pace_data1", int'(data_w[2]), 1);
        expect_steps(2, '{2, 0, 0, 0, 0, 0}, 1, 1'b1, "pace");

        // 6. Abort and backpressure on u0 (currently at 5)
        accept(0, 0);
        expect_steps(0, '{4, 3, 2, 1, 0, 0}, 5, 1'b1, "to0");
        accept(0, 6);
        tv[0] = 1'b1; tgt[0] = 3'd0;        // held while busy
        chk("bp_not_ready", int'(ready_w[0]), 0);
        expect_steps(0, '{1, 2, 0, 0, 0, 0}, 2, 1'b0, "bp_ramp");
        chk("bp_still_busy", int'(busy_w[0]), 1);
        wait_synch("abort");
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        chk("abort_data",  int'(data_w[0]),  2);
        chk("abort_busy",  int'(busy_w[0]),  0);
        chk("abort_done",  int'(done_w[0]),  0);
        chk("abort_ready", int'(ready_w[0]), 1);
        tick();
        tv[0] = 1'b0;
        chk("pending_accepted", int'(busy_w[0]), 1);
        expect_steps(0, '{1, 0, 0, 0, 0, 0}, 2, 1'b1, "after_abort");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_duty_ramp
`default_nettype wire
